// File: rtl/clk_d_pkg.sv
// Shared types and elaboration helpers for the switch-gated clock divider.
`timescale 1ns/100ps
package clk_d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  // Half-period counter width: max(1, clog2(DIV_RATIO/2)).
  function automatic int unsigned cnt_width(input int unsigned div_ratio);
    int unsigned half;
    half = div_ratio / 2;
    return (half <= 1) ? 1 : $clog2(half);
  endfunction

  function automatic bit div_ratio_ok(input int unsigned div_ratio);
    return (div_ratio >= 2) && ((div_ratio % 2) == 0);
  endfunction

  function automatic bit sync_stages_ok(input int unsigned stages);
    return stages >= 2;
  endfunction

endpackage

// File: rtl/clk_d_blk_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
`timescale 1ns/100ps
module bit_sync
  import clk_d_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_stages
    $error("bit_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_d_blk.sv
// Switch-gated glitch-free clock divider: 50 % duty clk_d, stopped cleanly low.
`timescale 1ns/100ps
module clk_d_blk
  import clk_d_pkg::*;
#(
  parameter int unsigned DIV_RATIO   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch,
  output logic clk_d
);

  localparam int unsigned HALF  = DIV_RATIO / 2;
  localparam int unsigned CNT_W = cnt_width(DIV_RATIO);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  if (!div_ratio_ok(DIV_RATIO)) begin : g_bad_div
    $error("clk_d_blk: DIV_RATIO must be even and >= 2");
  end

  logic             sw_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_d_q, clk_d_d;
  logic             toggle;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (switch),
    .q_o   (sw_s)
  );

  always_comb begin
    toggle  = (cnt_q == CNT_LAST);
    state_d = state_q;
    cnt_d   = toggle ? '0 : cnt_q + 1'b1;
    clk_d_d = clk_d_q ^ toggle;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        clk_d_d = 1'b0;
        if (sw_s) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!sw_s) begin
          if (!clk_d_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clk_d_d = 1'b0;
          end else begin
            // A stop seen on the edge that ends the high phase goes straight to IDLE.
            state_d = toggle ? ST_IDLE : ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        if (sw_s)        state_d = ST_RUN;
        else if (toggle) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        clk_d_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clk_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_d_q <= clk_d_d;
    end
  end

  assign clk_d = clk_d_q;

endmodule

// File: tb/tb_clk_d_blk.sv
// Directed bench for clk_d_blk with DIV_RATIO=4, SYNC_STAGES=2, 4 ns clk.
`timescale 1ns/100ps
module tb_clk_d_blk;

  logic clk;
  logic rst_n;
  logic switch;
  logic clk_d;

  int checks;
  int errors;

  typedef struct {
    logic rst_n;
    logic sw;
    logic exp;
  } vec_t;

  vec_t vq[$];

  clk_d_blk #(.DIV_RATIO(4), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .switch (switch),
    .clk_d  (clk_d)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: clk_d=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic e);
    vec_t v;
    v.rst_n = r;
    v.sw    = s;
    v.exp   = e;
    vq.push_back(v);
  endtask

  task automatic add_n(input int n, input logic r, input logic s, input logic e);
    for (int i = 0; i < n; i++) add(r, s, e);
  endtask

  initial begin
    logic prev;
    int   n;
    bit   seen;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    switch = 1'b0;

    // Each entry: inputs driven before edge k, clk_d expected just after edge k.
    add_n(3, 1'b0, 1'b1, 1'b0);          // reset held, switch high
    add_n(4, 1'b1, 1'b1, 1'b0);          // e1..e4: sync, enter RUN at e3
    add_n(2, 1'b1, 1'b1, 1'b1);          // e5 first rise (edge 5 after release)
    add_n(2, 1'b1, 1'b1, 1'b0);
    add_n(2, 1'b1, 1'b1, 1'b1);
    add  (1'b1, 1'b1, 1'b0);             // e11
    add  (1'b1, 1'b0, 1'b0);             // e12 switch drops
    add_n(2, 1'b1, 1'b0, 1'b1);          // e13 rise, e14 stop seen while high
    add_n(4, 1'b1, 1'b0, 1'b0);          // e15 falls on schedule, then idle
    add_n(4, 1'b1, 1'b1, 1'b0);          // e19..e22 restart
    add_n(2, 1'b1, 1'b1, 1'b1);          // e23 rise
    add  (1'b1, 1'b1, 1'b0);             // e25
    add  (1'b1, 1'b0, 1'b0);             // e26 one-cycle switch glitch
    add_n(2, 1'b1, 1'b1, 1'b1);          // e27 rise, e28 STOPPING
    add_n(2, 1'b1, 1'b1, 1'b0);          // e29 back in RUN
    add_n(2, 1'b1, 1'b1, 1'b1);
    add_n(2, 1'b1, 1'b1, 1'b0);
    add  (1'b1, 1'b1, 1'b1);             // e35 rise
    add  (1'b1, 1'b0, 1'b1);             // e36 drop one clk after rise
    add_n(5, 1'b1, 1'b0, 1'b0);          // e37 fall, stop while low, stays 0

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n  = vq[i].rst_n;
      switch = vq[i].sw;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), clk_d, vq[i].exp);
    end

    // Steady run: 20 periods, each phase exactly 2 clk cycles (8 ns).
    @(negedge clk);
    switch = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (clk_d === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL steady_first_rise: clk_d=%b expected=1 within 12 cycles", clk_d);
    end
    prev = 1'b1;
    for (int ph = 0; ph < 40; ph++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (clk_d === prev && n < 10);
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL steady_phase%0d: length=%0d cycles expected=2", ph, n);
      end
      prev = clk_d;
    end

    // Async reset pulse (3 ns) in the second cycle of a high phase.
    @(posedge clk);
    #0.5;
    check("high_before_rst", clk_d, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_clear", clk_d, 1'b0);
    #1.9;
    check("held_in_rst", clk_d, 1'b0);
    #0.1;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_restart_e%0d", e), clk_d, (e == 5 || e == 6) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
